microsequencer: RTL and testbench
=================================

// Module: microsequencer
// PURPOSE
//   Next-microinstruction address generator for the LC-3 control store.
//   Each cycle it selects the next 6-bit control-store address from one of:
//   - the J field of the current microinstruction, conditionally modified
//     by the COND bits;
//   - an opcode dispatch (IRD).
//   It also holds the BEN branch-enable flag.
//   It sits between the control store and the datapath status signals
//   (R, IR[15:9], NZP).
// PARAMETERS
//   RESET_ADDR  6'h12  control-store address loaded by reset (fetch state 18)
//   AW          6      control-store address width (fixed; not tested at other values)
// PORTS
//   clk        in   1  system clock; all state updates on posedge
//   reset      in   1  synchronous, active-high reset
//   j_field    in   6  J field of current microinstruction
//   cond_bits  in   3  COND field of current microinstruction
//   ird        in   1  1 = dispatch on opcode IR[15:12]
//   ld_ben     in   1  1 = load BEN register this edge
//   r_bit      in   1  memory ready (R)
//   ir_15_9    in   7  [6:3]=IR[15:12] opcode, [2]=IR11, [1]=IR10, [0]=IR9
//   nzp        in   3  condition codes {N,Z,P}
//   next_addr  out  6  registered next control-store address (uPC)
// BEHAVIOUR
//   - Registers: next_addr (6b), ben (1b). Both update only on posedge clk.
//   - Reset (sampled at posedge, reset=1): next_addr <= 6'h12, ben <= 0.
//     Reset has priority over every other input, including ld_ben and ird.
//   - BEN register:
//     - If ld_ben=1 and reset=0:
//       ben <= (IR11&N) | (IR10&Z) | (IR9&P), from ir_15_9 and nzp at that edge.
//     - Otherwise ben holds.
//   - next_addr selection at each non-reset posedge (priority order):
//     1. ird=1: next_addr <= {2'b00, ir_15_9[6:3]}. COND is ignored.
//     2. ird=0, by cond_bits:
//        - 000: J
//        - 001: J + (r_bit ? 2 : 0)
//        - 010: J + (ben ? 4 : 0)
//        - 011: J + (ir_15_9[2] ? 1 : 0)   (IR11 addressing-mode split)
//        - 100..111: J (reserved encodings fall back to plain J)
//   - Modification is a 6-bit addition, not a bitwise OR (e.g. J=20 with
//     BEN=1 gives 24). Results wrap modulo 64 (J=62, R=1 -> 0).
//   - The cond 010 path uses the ben value held before the edge. When ld_ben
//     and cond 010 occur in the same cycle, the old ben steers the branch and
//     the new ben is captured for later cycles.
//   - next_addr is a pure register output: 1-cycle latency from inputs, no
//     combinational path from inputs to next_addr.
//   - No handshake and no stall: an address is produced every cycle.
//     Waiting on memory is expressed by the microcode looping via COND=001
//     with R=0.
// TESTING
//   1. reset=1, one posedge -> next_addr=0x12; ben=0.
//   2. reset=0, J=18, COND=000 -> 18. J=33, COND=101 -> 33.
//      J=28, COND=110 -> 28.
//   3. J=28, COND=001:
//      - r_bit=0 -> 28
//      - r_bit=1 -> 30
//      - J=63, r_bit=1 -> 1 (wrap)
//   4. ird=1, ir_15_9=7'b0001000 -> 1. ir_15_9=7'b1111000 with COND=001,
//      r_bit=1 -> 15 (IRD wins).
//   5. BEN=0 case: ld_ben pulse with IR[11:9]=000, nzp=000; then J=22,
//      COND=010 -> 22.
//      BEN=1 case: ld_ben pulse with IR11=1, nzp=100; then J=20,
//      COND=010 -> 24.
//      Same-edge case: ld_ben=1 together with COND=010 uses the prior ben.
//   6. Reset mid-sequence with ld_ben=1 and ird=1 -> next_addr=0x12, ben=0;
//      a following J=4, COND=010 cycle -> 4.

Source files
------------

// File: rtl/microsequencer.sv
// LC-3 microsequencer: registered next control-store address (uPC)
// selected from opcode dispatch or the J field modified by COND; holds BEN.
module microsequencer #(
  parameter int          AW         = 6,
  parameter logic [AW-1:0] RESET_ADDR = 6'h12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] j_field,
  input  logic [2:0]    cond_bits,
  input  logic          ird,
  input  logic          ld_ben,
  input  logic          r_bit,
  input  logic [6:0]    ir_15_9,
  input  logic [2:0]    nzp,
  output logic [AW-1:0] next_addr
);

  logic [AW-1:0] addr_q, addr_d;
  logic          ben_q, ben_d;
  logic [AW-1:0] ofs;

  always_comb begin
    ofs = '0;
    unique case (cond_bits)
      3'b001:  ofs = r_bit      ? AW'(2) : '0;
      3'b010:  ofs = ben_q      ? AW'(4) : '0;
      3'b011:  ofs = ir_15_9[2] ? AW'(1) : '0;
      default: ofs = '0;
    endcase
  end

  // J modification is a true add that wraps at the address width
  always_comb begin
    addr_d = j_field + ofs;
    if (ird)
      addr_d = {{(AW-4){1'b0}}, ir_15_9[6:3]};
  end

  always_comb begin
    ben_d = ben_q;
    if (ld_ben)
      ben_d = |(ir_15_9[2:0] & nzp);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q <= RESET_ADDR;
      ben_q  <= 1'b0;
    end else begin
      addr_q <= addr_d;
      ben_q  <= ben_d;
    end
  end

  assign next_addr = addr_q;

endmodule

// File: tb/tb_microsequencer.sv
// Testbench for microsequencer: directed cases plus random
// vectors checked against an arithmetic reference model.
module tb_microsequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] j_field;
  logic [2:0] cond_bits;
  logic       ird;
  logic       ld_ben;
  logic       r_bit;
  logic [6:0] ir_15_9;
  logic [2:0] nzp;
  logic [5:0] next_addr;

  int n_vec = 0;
  int n_err = 0;

  bit m_ben = 1'b0;
  int m_addr = 0;

  always #5 clk = ~clk;

  microsequencer dut (
    .clk       (clk),
    .reset     (reset),
    .j_field   (j_field),
    .cond_bits (cond_bits),
    .ird       (ird),
    .ld_ben    (ld_ben),
    .r_bit     (r_bit),
    .ir_15_9   (ir_15_9),
    .nzp       (nzp),
    .next_addr (next_addr)
  );

  task automatic chk(input string tag, input logic [5:0] got,
                     input logic [5:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: uses plain integer arithmetic on the old BEN.
  task automatic model(input bit rst, input int j, input int c,
                       input bit i, input bit ld, input bit r,
                       input bit [6:0] ir, input bit [2:0] cc);
    int add;
    bit nb;
    if (rst) begin
      m_addr = 18;
      m_ben  = 1'b0;
      return;
    end
    add = 0;
    if (c == 1 && r)     add = 2;
    if (c == 2 && m_ben) add = 4;
    if (c == 3 && ir[2]) add = 1;
    if (i) m_addr = ir / 8;
    else   m_addr = (j + add) % 64;
    nb = (ir[2] && cc[2]) || (ir[1] && cc[1]) || (ir[0] && cc[0]);
    if (ld) m_ben = nb;
  endtask

  task automatic apply(input string tag, input bit rst, input int j,
                       input int c, input bit i, input bit ld,
                       input bit r, input bit [6:0] ir,
                       input bit [2:0] cc);
    reset     = rst;
    j_field   = 6'(j);
    cond_bits = 3'(c);
    ird       = i;
    ld_ben    = ld;
    r_bit     = r;
    ir_15_9   = ir;
    nzp       = cc;
    model(rst, j, c, i, ld, r, ir, cc);
    @(posedge clk);
    #1;
    chk(tag, next_addr, 6'(m_addr));
  endtask

  initial begin
    apply("reset",     1, 0,  0, 0, 0, 0, 7'b0, 3'b0);
    apply("j18_c000",  0, 18, 0, 0, 0, 0, 7'b0, 3'b0);
    apply("j33_c101",  0, 33, 5, 0, 0, 0, 7'b0, 3'b0);
    apply("j28_c110",  0, 28, 6, 0, 0, 0, 7'b0, 3'b0);
    apply("r0",        0, 28, 1, 0, 0, 0, 7'b0, 3'b0);
    apply("r1",        0, 28, 1, 0, 0, 1, 7'b0, 3'b0);
    apply("r_wrap",    0, 63, 1, 0, 0, 1, 7'b0, 3'b0);
    apply("ird_op1",   0, 5,  0, 1, 0, 0, 7'b0001000, 3'b0);
    apply("ird_wins",  0, 5,  1, 1, 0, 1, 7'b1111000, 3'b0);
    apply("ir11_0",    0, 40, 3, 0, 0, 0, 7'b0000011, 3'b0);
    apply("ir11_1",    0, 40, 3, 0, 0, 0, 7'b0000100, 3'b0);
    apply("ldben0",    0, 1,  0, 0, 1, 0, 7'b0000000, 3'b000);
    apply("ben0_br",   0, 22, 2, 0, 0, 0, 7'b0, 3'b0);
    apply("ldben1",    0, 1,  0, 0, 1, 0, 7'b0000100, 3'b100);
    apply("ben1_br",   0, 20, 2, 0, 0, 0, 7'b0, 3'b0);
    apply("same_edge", 0, 20, 2, 0, 1, 0, 7'b0000000, 3'b000);
    apply("after_clr", 0, 20, 2, 0, 0, 0, 7'b0, 3'b0);
    apply("ldben_z",   0, 1,  0, 0, 1, 0, 7'b0000010, 3'b010);
    apply("ben_wrap",  0, 62, 2, 0, 0, 0, 7'b0, 3'b0);
    apply("rst_mid",   1, 9,  2, 1, 1, 1, 7'b1111111, 3'b111);
    apply("post_rst",  0, 4,  2, 0, 0, 0, 7'b0, 3'b0);

    for (int k = 0; k < 400; k++) begin
      apply("rand",
            ($urandom_range(0, 31) == 0),
            int'($urandom_range(0, 63)),
            int'($urandom_range(0, 7)),
            ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 2) == 0),
            1'($urandom),
            7'($urandom),
            3'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
